// File: rtl/spi_transaction_scheduler.sv
// spi_transaction_scheduler: queues host read/write requests and issues them one at a time to quick_spi
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   req_valid/req_ready             host request handshake (push into the request FIFO)
//   req_slave/req_operation/req_data request fields (1 = write, 0 = read)
//   rsp_valid/rsp_data/rsp_error    one-cycle response strobe, read data, timeout flag
//   busy, fifo_count                activity flag and number of queued requests
//   spi_*                           command/response interface to quick_spi
module spi_transaction_scheduler #(
    parameter int NUMBER_OF_SLAVES    = 2,
    parameter int INCOMING_DATA_WIDTH = 8,
    parameter int OUTGOING_DATA_WIDTH = 16,
    parameter int FIFO_DEPTH          = 4,
    parameter int TIMEOUT_CYCLES      = 1024
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [NUMBER_OF_SLAVES-1:0]    req_slave,
    input  logic                           req_operation,
    input  logic [OUTGOING_DATA_WIDTH-1:0] req_data,
    output logic                           rsp_valid,
    output logic [INCOMING_DATA_WIDTH-1:0] rsp_data,
    output logic                           rsp_error,
    output logic                           busy,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
    output logic                           spi_enable,
    output logic                           spi_start_transaction,
    output logic [NUMBER_OF_SLAVES-1:0]    spi_slave,
    output logic                           spi_operation,
    output logic [OUTGOING_DATA_WIDTH-1:0] spi_outgoing_data,
    input  logic                           spi_end_of_transaction,
    input  logic [INCOMING_DATA_WIDTH-1:0] spi_incoming_data
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam int EW = NUMBER_OF_SLAVES + 1 + OUTGOING_DATA_WIDTH;
    localparam logic [AW:0]   FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_EOT, RESPOND, GAP} state_t;

    state_t                         state_q, state_d;
    logic [EW-1:0]                  mem_q [FIFO_DEPTH];
    logic [AW-1:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]                    count_q, count_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [NUMBER_OF_SLAVES-1:0]    slave_q, slave_d;
    logic                           op_q, op_d;
    logic [OUTGOING_DATA_WIDTH-1:0] data_q, data_d;
    logic [INCOMING_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                           err_q, err_d;
    logic                           en_q;
    logic                           push, pop;

    // req_ready is forced low while reset_n is asserted so every output reads 0 in reset
    assign req_ready = reset_n & (count_q != FULL);
    assign push      = req_valid & req_ready;
    assign pop       = (state_q == ISSUE);

    // FIFO storage needs no reset: only entries below count_q are ever read
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {req_slave, req_operation, req_data};
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
        cnt_d    = cnt_q;
        slave_d  = slave_q;
        op_d     = op_q;
        data_d   = data_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                // head entry is loaded on the IDLE->ISSUE edge so it is on the bus during ISSUE
                if (count_q != '0) begin
                    state_d = ISSUE;
                    {slave_d, op_d, data_d} = mem_q[rd_ptr_q];
                end
            end
            ISSUE: state_d = WAIT_EOT;
            WAIT_EOT: begin
                cnt_d = cnt_q + 1'b1;
                // EOT is checked first so it wins over a simultaneous timeout
                if (spi_end_of_transaction) begin
                    state_d = RESPOND;
                    rdata_d = op_q ? '0 : spi_incoming_data;
                    err_d   = 1'b0;
                end else if (cnt_q == LAST) begin
                    state_d = RESPOND;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            RESPOND: begin
                state_d = GAP;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cnt_q    <= '0;
            slave_q  <= '0;
            op_q     <= 1'b0;
            data_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            en_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cnt_q    <= cnt_d;
            slave_q  <= slave_d;
            op_q     <= op_d;
            data_q   <= data_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            en_q     <= 1'b1;
        end
    end

    assign rsp_valid             = (state_q == RESPOND);
    assign rsp_data              = rsp_valid ? rdata_q : '0;
    assign rsp_error             = rsp_valid & err_q;
    assign busy                  = (state_q != IDLE) | (count_q != '0);
    assign fifo_count            = count_q;
    assign spi_enable            = en_q;
    assign spi_start_transaction = (state_q == ISSUE);
    assign spi_slave             = slave_q;
    assign spi_operation         = op_q;
    assign spi_outgoing_data     = data_q;
endmodule

// File: tb/tb_spi_transaction_scheduler.sv
// tb_spi_transaction_scheduler: scoreboard bench for spi_transaction_scheduler with a behavioural quick_spi model
module tb_spi_transaction_scheduler;
    localparam int NS = 2;
    localparam int IW = 8;
    localparam int OW = 16;
    localparam int FD = 4;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [NS-1:0] req_slave = '0;
    logic          req_operation = 1'b0;
    logic [OW-1:0] req_data = '0;
    logic          rsp_valid;
    logic [IW-1:0] rsp_data;
    logic          rsp_error;
    logic          busy;
    logic [$clog2(FD):0] fifo_count;
    logic          spi_enable;
    logic          spi_start_transaction;
    logic [NS-1:0] spi_slave;
    logic          spi_operation;
    logic [OW-1:0] spi_outgoing_data;
    logic          eot = 1'b0;
    logic [IW-1:0] incoming = '0;

    always #5 clk = ~clk;

    spi_transaction_scheduler #(
        .NUMBER_OF_SLAVES(NS), .INCOMING_DATA_WIDTH(IW), .OUTGOING_DATA_WIDTH(OW),
        .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_slave(req_slave),
        .req_operation(req_operation), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
        .busy(busy), .fifo_count(fifo_count),
        .spi_enable(spi_enable), .spi_start_transaction(spi_start_transaction),
        .spi_slave(spi_slave), .spi_operation(spi_operation), .spi_outgoing_data(spi_outgoing_data),
        .spi_end_of_transaction(eot), .spi_incoming_data(incoming)
    );

    typedef struct {
        int            delay;
        logic [IW-1:0] data;
        bit            hang;
    } plan_t;

    plan_t           plan_q [$];
    logic [NS+OW:0]  exp_iss [$];
    logic [IW:0]     exp_rsp [$];
    int              start_log [$];
    int              rsp_log [$];
    int              cyc = 0;
    int              last_eot_cyc = 0;
    int              cmp = 0;
    int              err = 0;
    logic [NS+OW:0]  held = '0;
    logic [IW:0]     e_rsp;
    bit              inflight = 0;
    bit              hold_bad = 0;
    plan_t           mp;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset_n) begin
            inflight = 0;
            hold_bad = 0;
        end else begin
            if (inflight && {spi_slave, spi_operation, spi_outgoing_data} !== held) hold_bad = 1;
            if (spi_start_transaction) begin
                start_log.push_back(cyc);
                chk("start_expected", exp_iss.size() != 0, 1);
                if (exp_iss.size() != 0) chk("issue_fields", {spi_slave, spi_operation, spi_outgoing_data}, exp_iss.pop_front());
                held = {spi_slave, spi_operation, spi_outgoing_data};
                inflight = 1;
                hold_bad = 0;
            end
            if (rsp_valid) begin
                rsp_log.push_back(cyc);
                chk("rsp_expected", exp_rsp.size() != 0, 1);
                if (exp_rsp.size() != 0) begin
                    e_rsp = exp_rsp.pop_front();
                    chk("rsp_err_data", {rsp_error, rsp_data}, e_rsp);
                    if (!e_rsp[IW]) chk("rsp_latency", cyc, last_eot_cyc + 1);
                end
                chk("hold_stable", hold_bad, 0);
                inflight = 0;
            end
        end
    end

    // quick_spi model: one EOT pulse per start, after the planned delay, unless told to hang
    always begin
        @(negedge clk);
        if (reset_n && spi_start_transaction && plan_q.size() != 0) begin
            mp = plan_q.pop_front();
            if (!mp.hang) begin
                @(posedge clk);
                repeat (mp.delay) @(posedge clk);
                #1 eot = 1'b1;
                incoming = mp.data;
                last_eot_cyc = cyc;
                @(posedge clk);
                #1 eot = 1'b0;
                incoming = '0;
            end
        end
    end

    task automatic send(input logic [NS-1:0] s, input logic op, input logic [OW-1:0] d,
                        input int dly, input logic [IW-1:0] rd, input bit hang, output int acc);
        plan_t p;
        int w;
        p.delay = dly;
        p.data = rd;
        p.hang = hang;
        plan_q.push_back(p);
        exp_iss.push_back({s, op, d});
        exp_rsp.push_back(hang ? {1'b1, IW'(0)} : {1'b0, (op ? IW'(0) : rd)});
        req_valid = 1'b1;
        req_slave = s;
        req_operation = op;
        req_data = d;
        w = 0;
        while (!req_ready && w < 300) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("accept_bound", w < 300, 1);
        @(posedge clk);
        #1;
        acc = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((exp_rsp.size() != 0 || busy) && w < 1000) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("drain_bound", w < 1000, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc, acc2, s0, r0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_enable", spi_enable, 0);
        chk("rst_start", spi_start_transaction, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_count", fifo_count, 0);
        reset_n = 1'b1;
        #1;
        chk("rel_req_ready", req_ready, 1);
        chk("rel_enable_pre_edge", spi_enable, 0);
        @(posedge clk);
        #1;
        chk("rel_enable_post_edge", spi_enable, 1);

        // write 16'hA55A to slave 1; model drives FF so a write must still return 0
        s0 = start_log.size();
        send(2'd1, 1'b1, 16'hA55A, 5, 8'hFF, 0, acc);
        wait_idle();
        chk("t1_start_cycle", start_log[s0], acc + 1);
        chk("t1_start_count", start_log.size() - s0, 1);

        // read slave 0 returns 3C, then a queued write must wait for GAP
        s0 = start_log.size();
        r0 = rsp_log.size();
        send(2'd0, 1'b0, 16'h0000, 3, 8'h3C, 0, acc);
        send(2'd1, 1'b1, 16'h1234, 2, 8'hFF, 0, acc2);
        wait_idle();
        chk("t2_gap_to_next_start", start_log[s0 + 1] - rsp_log[r0], 3);

        // six back-to-back pushes while the first transfer is held off
        r0 = rsp_log.size();
        send(2'd0, 1'b0, 16'h1001, 30, 8'h11, 0, acc);
        send(2'd1, 1'b1, 16'h1002, 1, 8'hFF, 0, acc);
        send(2'd2, 1'b0, 16'h1003, 1, 8'h33, 0, acc);
        chk("t3_same_edge_push_pop", fifo_count, 2);
        send(2'd3, 1'b1, 16'h1004, 0, 8'hFF, 0, acc);
        send(2'd0, 1'b0, 16'h1005, 2, 8'h55, 0, acc);
        chk("t3_full_count", fifo_count, 4);
        chk("t3_full_ready", req_ready, 0);
        send(2'd1, 1'b0, 16'h1006, 1, 8'h66, 0, acc);
        wait_idle();
        chk("t3_response_count", rsp_log.size() - r0, 6);

        // timeout with a request queued behind it
        s0 = start_log.size();
        r0 = rsp_log.size();
        send(2'd1, 1'b0, 16'hBEEF, 0, 8'h77, 1, acc);
        send(2'd0, 1'b0, 16'h0F0F, 1, 8'h5A, 0, acc);
        wait_idle();
        chk("t4_timeout_latency", rsp_log[r0] - start_log[s0], TO + 1);
        chk("t4_next_issue", start_log[s0 + 1] - rsp_log[r0], 3);

        // stray EOT while idle
        r0 = rsp_log.size();
        @(posedge clk);
        #1 eot = 1'b1;
        @(posedge clk);
        #1 eot = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("t5_stray_eot_rsp", rsp_log.size() - r0, 0);
        chk("t5_stray_eot_busy", busy, 0);

        // reset while waiting for EOT with three requests queued
        send(2'd1, 1'b1, 16'hC0DE, 0, 8'h00, 1, acc);
        send(2'd0, 1'b0, 16'h2001, 1, 8'h21, 0, acc);
        send(2'd1, 1'b0, 16'h2002, 1, 8'h22, 0, acc);
        send(2'd2, 1'b1, 16'h2003, 1, 8'hFF, 0, acc);
        chk("t6_queued", fifo_count, 3);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_start", spi_start_transaction, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_count", fifo_count, 0);
        chk("t6_rst_bus", {spi_slave, spi_operation, spi_outgoing_data}, 0);
        chk("t6_rst_enable", spi_enable, 0);
        chk("t6_rst_ready", req_ready, 0);
        plan_q.delete();
        exp_iss.delete();
        exp_rsp.delete();
        s0 = start_log.size();
        r0 = rsp_log.size();
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("t6_no_rsp_after_reset", rsp_log.size() - r0, 0);
        chk("t6_no_start_after_reset", start_log.size() - s0, 0);
        chk("t6_count_after_reset", fifo_count, 0);

        // block still works after the reset
        send(2'd3, 1'b0, 16'h7777, 2, 8'hA5, 0, acc);
        wait_idle();
        chk("t7_rsp_after_reset", rsp_log.size() - r0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule
